frog_mover: RTL and testbench

Parametrised grid-hop movement controller for the player sprite. Takes debounced d-pad levels, produces per-frame pixel coordinates with animated hops, hold-to-repeat, a one-deep move queue, and horizontal carry by moving platforms. Sits between the input debouncers and the collision and render logic. Reports goal-row arrival and being swept off-screen to the game FSM.

---
 rtl/game_pkg.sv | 44 ++++
 rtl/frog_mover_if.sv | 35 +++
 rtl/frog_mover_dir_repeat.sv | 56 +++++
 rtl/frog_mover.sv | 187 ++++++++++++++++++
 tb/tb_frog_mover.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared game types and direction helpers
// Purpose: game state and direction enums plus per-direction unit vectors,
//          shared by the game FSM, renderer and frog_mover.
// Ports:   none (package)
package game_pkg;

    typedef enum logic [1:0] {
        MENU    = 2'd0,
        PLAYING = 2'd1,
        DEAD    = 2'd2,
        WIN     = 2'd3
    } game_state_t;

    typedef enum logic [1:0] {
        LEFT  = 2'd0,
        DOWN  = 2'd1,
        UP    = 2'd2,
        RIGHT = 2'd3
    } dir_t;

    typedef enum logic {
        HOP_IDLE = 1'b0,
        HOP_MOVE = 1'b1
    } hop_state_t;

    // Unit step along x for a direction: -1, 0 or +1.
    function automatic logic signed [1:0] dir_to_dx(input dir_t d);
        case (d)
            LEFT:    return -2'sd1;
            RIGHT:   return 2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

    // Unit step along y for a direction; screen y grows downward.
    function automatic logic signed [1:0] dir_to_dy(input dir_t d);
        case (d)
            UP:      return -2'sd1;
            DOWN:    return 2'sd1;
            default: return 2'sd0;
        endcase
    endfunction

endpackage

// File: rtl/frog_mover_if.sv
// rtl/frog_mover_if.sv - control/status bundle between the game logic and frog_mover
// Purpose: groups game-side inputs and sprite outputs of frog_mover.
// Ports:   master = game side (drives state/tick/respawn/init/dpad/carry),
//          slave  = frog_mover (drives pos/hopping/facing/reached_end/swept).
interface frog_mover_if #(
    parameter int COORD_W = 10,
    parameter int CARRY_W = 4
);
    import game_pkg::*;

    game_state_t                state;
    logic                       frame_tick;
    logic                       respawn;
    logic [COORD_W-1:0]         init_x;
    logic [COORD_W-1:0]         init_y;
    logic [3:0]                 dpad_level;
    logic signed [CARRY_W-1:0]  carry_vx;
    logic [COORD_W-1:0]         pos_x;
    logic [COORD_W-1:0]         pos_y;
    logic                       hopping;
    dir_t                       facing;
    logic                       reached_end;
    logic                       swept;

    modport master (
        output state, frame_tick, respawn, init_x, init_y, dpad_level, carry_vx,
        input  pos_x, pos_y, hopping, facing, reached_end, swept
    );

    modport slave (
        input  state, frame_tick, respawn, init_x, init_y, dpad_level, carry_vx,
        output pos_x, pos_y, hopping, facing, reached_end, swept
    );

endinterface

// File: rtl/frog_mover_dir_repeat.sv
// rtl/frog_mover_dir_repeat.sv - per-button edge detect with hold-to-repeat
// Purpose: pulses o_req on a rising edge of i_level, then after REPEAT_DELAY
//          held frame ticks, then every REPEAT_RATE held frame ticks.
// Ports:   clk, reset (sync, active-high), i_clear (drop edge and counter
//          state), i_enable (counting allowed; counter held clear otherwise),
//          i_level, i_tick, o_req.
module dir_repeat #(
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic i_clear,
    input  logic i_enable,
    input  logic i_level,
    input  logic i_tick,
    output logic o_req
);
    localparam int MAX_P = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int CNT_W = $clog2(MAX_P + 1);

    logic             r_prev;
    logic             r_first;
    logic [CNT_W-1:0] r_cnt;
    logic             w_rise;
    logic             w_fire;
    logic [CNT_W-1:0] w_target;

    assign w_rise   = i_level & ~r_prev;
    assign w_target = r_first ? CNT_W'(REPEAT_DELAY) : CNT_W'(REPEAT_RATE);
    // A tick coinciding with the press edge is not counted toward the delay.
    assign w_fire   = i_enable & i_level & r_prev & i_tick & ((r_cnt + CNT_W'(1)) == w_target);
    assign o_req    = i_enable & (w_rise | w_fire);

    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_prev  <= 1'b0;
            r_first <= 1'b1;
            r_cnt   <= '0;
        end else begin
            r_prev <= i_level;
            if (!i_enable || !i_level || w_rise) begin
                r_first <= 1'b1;
                r_cnt   <= '0;
            end else if (i_tick) begin
                if (w_fire) begin
                    r_first <= 1'b0;
                    r_cnt   <= '0;
                end else begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/frog_mover.sv
// rtl/frog_mover.sv - grid-hop movement controller for the player sprite
// Purpose: priority-encodes d-pad requests, queues one move during a hop,
//          bounds-checks, animates hops over HOP_FRAMES ticks and applies
//          platform carry with off-screen sweep detection.
// Ports:   clk, reset (sync, active-high), bus (frog_mover_if.slave).
module frog_mover #(
    parameter int COORD_W      = 10,
    parameter int SCREEN_W     = 640,
    parameter int SCREEN_H     = 480,
    parameter int FROG_SIZE    = 32,
    parameter int STEP         = 32,
    parameter int HOP_FRAMES   = 4,
    parameter int REPEAT_DELAY = 16,
    parameter int REPEAT_RATE  = 8,
    parameter int END_Y        = 15,
    parameter int CARRY_W      = 4
) (
    input  logic         clk,
    input  logic         reset,
    frog_mover_if.slave  bus
);
    import game_pkg::*;

    localparam int HOP_PX = STEP / HOP_FRAMES;
    localparam int X_MAX  = SCREEN_W - FROG_SIZE;
    localparam int Y_MAX  = SCREEN_H - FROG_SIZE;
    localparam int FC_W   = (HOP_FRAMES > 1) ? $clog2(HOP_FRAMES) : 1;

    typedef logic signed [COORD_W+1:0] scoord_t;

    hop_state_t         r_state,     w_state_n;
    logic [FC_W-1:0]    r_frame_cnt, w_frame_cnt_n;
    dir_t               r_hop_dir,   w_hop_dir_n;
    logic               r_q_valid,   w_q_valid_n;
    dir_t               r_q_dir,     w_q_dir_n;
    dir_t               r_facing,    w_facing_n;
    logic [COORD_W-1:0] r_pos_x,     w_pos_x_n;
    logic [COORD_W-1:0] r_pos_y,     w_pos_y_n;
    logic               r_reached,   w_reached_n;
    logic               r_swept,     w_swept_n;

    logic               w_playing;
    logic [3:0]         w_req;
    logic               w_req_valid;
    dir_t               w_req_dir;
    logic               w_eval_valid;
    dir_t               w_eval_dir;
    logic               w_move_ok;
    scoord_t            w_dx, w_dy, w_x_sum, w_y_sum;

    assign w_playing = (bus.state == PLAYING);

    for (genvar i = 0; i < 4; i++) begin : g_rep
        dir_repeat #(
            .REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_RATE  (REPEAT_RATE)
        ) u_rep (
            .clk      (clk),
            .reset    (reset),
            .i_clear  (bus.respawn),
            .i_enable (w_playing),
            .i_level  (bus.dpad_level[i]),
            .i_tick   (bus.frame_tick),
            .o_req    (w_req[i])
        );
    end

    // Request priority UP > DOWN > LEFT > RIGHT (bit order 2,1,0,3).
    always_comb begin
        w_req_valid = |w_req;
        w_req_dir   = RIGHT;
        if (w_req[2])      w_req_dir = UP;
        else if (w_req[1]) w_req_dir = DOWN;
        else if (w_req[0]) w_req_dir = LEFT;
    end

    always_comb begin
        w_state_n     = r_state;
        w_frame_cnt_n = r_frame_cnt;
        w_hop_dir_n   = r_hop_dir;
        w_q_valid_n   = r_q_valid;
        w_q_dir_n     = r_q_dir;
        w_facing_n    = r_facing;
        w_pos_x_n     = r_pos_x;
        w_pos_y_n     = r_pos_y;
        w_reached_n   = r_reached;
        w_swept_n     = 1'b0;
        w_eval_valid  = 1'b0;
        w_eval_dir    = w_req_dir;
        w_move_ok     = 1'b0;
        w_dx          = '0;
        w_dy          = '0;
        w_x_sum       = '0;
        w_y_sum       = '0;

        if (w_playing) begin
            w_reached_n = (int'(r_pos_y) <= END_Y) && (r_state == HOP_IDLE);
            case (r_state)
                HOP_IDLE: begin
                    // A queued move takes precedence over a fresh request.
                    if (r_q_valid) begin
                        w_eval_valid = 1'b1;
                        w_eval_dir   = r_q_dir;
                        w_q_valid_n  = 1'b0;
                    end else if (w_req_valid) begin
                        w_eval_valid = 1'b1;
                    end
                    case (w_eval_dir)
                        UP:      w_move_ok = int'(r_pos_y) >= STEP;
                        DOWN:    w_move_ok = int'(r_pos_y) + STEP <= Y_MAX;
                        LEFT:    w_move_ok = int'(r_pos_x) >= STEP;
                        default: w_move_ok = int'(r_pos_x) + STEP <= X_MAX;
                    endcase
                    if (w_eval_valid) begin
                        w_facing_n = w_eval_dir;
                        if (w_move_ok) begin
                            w_state_n     = HOP_MOVE;
                            w_frame_cnt_n = '0;
                            w_hop_dir_n   = w_eval_dir;
                        end
                    end
                end
                default: begin
                    if (w_req_valid && !r_q_valid) begin
                        w_q_valid_n = 1'b1;
                        w_q_dir_n   = w_req_dir;
                    end
                    if (bus.frame_tick) begin
                        w_dx = scoord_t'(int'(dir_to_dx(r_hop_dir)) * HOP_PX);
                        w_dy = scoord_t'(int'(dir_to_dy(r_hop_dir)) * HOP_PX);
                        if (r_frame_cnt == FC_W'(HOP_FRAMES - 1)) begin
                            w_state_n = HOP_IDLE;
                        end else begin
                            w_frame_cnt_n = r_frame_cnt + FC_W'(1);
                        end
                    end
                end
            endcase

            if (bus.frame_tick) begin
                w_x_sum = $signed({2'b00, r_pos_x}) + w_dx + scoord_t'(bus.carry_vx);
                w_y_sum = $signed({2'b00, r_pos_y}) + w_dy;
                w_pos_y_n = w_y_sum[COORD_W-1:0];
                // Off-screen carry leaves x untouched and reports the sweep.
                if (w_x_sum < 0 || w_x_sum > scoord_t'(X_MAX)) begin
                    w_swept_n = 1'b1;
                end else begin
                    w_pos_x_n = w_x_sum[COORD_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || bus.respawn) begin
            r_state     <= HOP_IDLE;
            r_frame_cnt <= '0;
            r_hop_dir   <= UP;
            r_q_valid   <= 1'b0;
            r_q_dir     <= UP;
            r_facing    <= UP;
            r_pos_x     <= bus.init_x;
            r_pos_y     <= bus.init_y;
            r_reached   <= 1'b0;
            r_swept     <= 1'b0;
        end else begin
            r_state     <= w_state_n;
            r_frame_cnt <= w_frame_cnt_n;
            r_hop_dir   <= w_hop_dir_n;
            r_q_valid   <= w_q_valid_n;
            r_q_dir     <= w_q_dir_n;
            r_facing    <= w_facing_n;
            r_pos_x     <= w_pos_x_n;
            r_pos_y     <= w_pos_y_n;
            r_reached   <= w_reached_n;
            r_swept     <= w_swept_n;
        end
    end

    assign bus.pos_x       = r_pos_x;
    assign bus.pos_y       = r_pos_y;
    assign bus.hopping     = (r_state == HOP_MOVE);
    assign bus.facing      = r_facing;
    assign bus.reached_end = r_reached;
    assign bus.swept       = r_swept;

endmodule

// File: tb/tb_frog_mover.sv
// tb/tb_frog_mover.sv - directed self-checking bench for frog_mover
module tb_frog_mover;
    import game_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_errors;

    frog_mover_if #(.COORD_W(10), .CARRY_W(4)) bus ();

    frog_mover u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic tick_once();
        bus.frame_tick = 1'b1;
        idle(1);
        bus.frame_tick = 1'b0;
    endtask

    task automatic tick();
        tick_once();
        idle(2);
    endtask

    task automatic press(input logic [3:0] lvl);
        bus.dpad_level = lvl;
        idle(1);
    endtask

    task automatic respawn_at(input int x, input int y);
        bus.init_x  = 10'(x);
        bus.init_y  = 10'(y);
        bus.respawn = 1'b1;
        idle(1);
        bus.respawn = 1'b0;
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        reset          = 1'b1;
        bus.state      = PLAYING;
        bus.frame_tick = 1'b0;
        bus.respawn    = 1'b0;
        bus.init_x     = 10'd320;
        bus.init_y     = 10'd448;
        bus.dpad_level = 4'b0000;
        bus.carry_vx   = 4'sd0;
        idle(3);
        reset = 1'b0;
        idle(1);

        check_val("reset_x", int'(bus.pos_x), 320);
        check_val("reset_y", int'(bus.pos_y), 448);
        check_val("reset_hop", int'(bus.hopping), 0);
        check_val("reset_facing", int'(bus.facing), 2);
        check_val("reset_end", int'(bus.reached_end), 0);

        // Single hop up: 8 px per tick.
        press(4'b0100);
        check_val("hop_start", int'(bus.hopping), 1);
        check_val("hop_facing", int'(bus.facing), 2);
        bus.dpad_level = 4'b0000;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check_val($sformatf("hop_y%0d", k), int'(bus.pos_y), 448 - 8 * k);
        end
        check_val("hop_done", int'(bus.hopping), 0);

        // Down rejected at the bottom edge.
        respawn_at(320, 448);
        press(4'b0010);
        bus.dpad_level = 4'b0000;
        check_val("down_rej_facing", int'(bus.facing), 1);
        check_val("down_rej_hop", int'(bus.hopping), 0);

        // Left rejected at x=0.
        respawn_at(0, 448);
        press(4'b0001);
        bus.dpad_level = 4'b0000;
        check_val("left_rej_facing", int'(bus.facing), 0);
        check_val("left_rej_hop", int'(bus.hopping), 0);
        tick();
        check_val("left_rej_x", int'(bus.pos_x), 0);

        // Right rejected at x=608.
        respawn_at(608, 448);
        press(4'b1000);
        bus.dpad_level = 4'b0000;
        check_val("right_rej_facing", int'(bus.facing), 3);
        check_val("right_rej_hop", int'(bus.hopping), 0);

        // Auto-repeat: hold right from x=0; hops start at ticks 0,16,24,32.
        respawn_at(0, 448);
        idle(1);
        for (int k = 0; k < 40; k++) begin
            if (k == 0) bus.dpad_level = 4'b1000;
            tick_once();
            if (k == 0)  check_val("rep_t0_hop", int'(bus.hopping), 1);
            if (k == 15) check_val("rep_t15_hop", int'(bus.hopping), 0);
            if (k == 16) check_val("rep_t16_hop", int'(bus.hopping), 1);
            if (k == 16) check_val("rep_t16_x", int'(bus.pos_x), 32);
            if (k == 23) check_val("rep_t23_hop", int'(bus.hopping), 0);
            if (k == 24) check_val("rep_t24_x", int'(bus.pos_x), 64);
            if (k == 24) check_val("rep_t24_hop", int'(bus.hopping), 1);
            if (k == 32) check_val("rep_t32_x", int'(bus.pos_x), 96);
            if (k == 32) check_val("rep_t32_hop", int'(bus.hopping), 1);
            idle(2);
        end
        bus.dpad_level = 4'b0000;
        idle(2);
        check_val("rep_final_x", int'(bus.pos_x), 128);
        check_val("rep_final_hop", int'(bus.hopping), 0);

        // Queue: UP queued at hop tick 1, DOWN dropped at hop tick 2.
        respawn_at(320, 448);
        press(4'b0100);
        bus.dpad_level = 4'b0000;
        tick();
        press(4'b0100);
        bus.dpad_level = 4'b0000;
        tick();
        press(4'b0010);
        bus.dpad_level = 4'b0000;
        tick();
        tick_once();
        check_val("q_first_y", int'(bus.pos_y), 416);
        check_val("q_first_end", int'(bus.hopping), 0);
        idle(2);
        check_val("q_second_hop", int'(bus.hopping), 1);
        check_val("q_second_facing", int'(bus.facing), 2);
        for (int k = 0; k < 4; k++) tick();
        check_val("q_final_y", int'(bus.pos_y), 384);
        check_val("q_final_hop", int'(bus.hopping), 0);
        check_val("q_final_facing", int'(bus.facing), 2);

        // Carry to the left edge, then swept.
        respawn_at(2, 448);
        bus.carry_vx = -4'sd2;
        tick_once();
        check_val("carry_x0", int'(bus.pos_x), 0);
        check_val("carry_noswept", int'(bus.swept), 0);
        idle(2);
        tick_once();
        check_val("swept_pulse", int'(bus.swept), 1);
        check_val("swept_x", int'(bus.pos_x), 0);
        idle(1);
        check_val("swept_clear", int'(bus.swept), 0);
        bus.carry_vx = 4'sd0;

        // Goal row.
        respawn_at(320, 32);
        idle(1);
        check_val("goal_pre", int'(bus.reached_end), 0);
        press(4'b0100);
        bus.dpad_level = 4'b0000;
        for (int k = 0; k < 4; k++) tick();
        check_val("goal_y", int'(bus.pos_y), 0);
        check_val("goal_end", int'(bus.reached_end), 1);
        press(4'b0100);
        bus.dpad_level = 4'b0000;
        check_val("up_rej_hop", int'(bus.hopping), 0);

        // DEAD freezes a hop in progress; respawn restores start.
        respawn_at(320, 448);
        press(4'b0100);
        bus.dpad_level = 4'b0000;
        tick();
        tick();
        check_val("dead_pre_y", int'(bus.pos_y), 432);
        bus.state = DEAD;
        tick();
        tick();
        check_val("dead_y", int'(bus.pos_y), 432);
        check_val("dead_hop", int'(bus.hopping), 1);
        press(4'b0010);
        bus.dpad_level = 4'b0000;
        check_val("dead_facing", int'(bus.facing), 2);
        respawn_at(320, 448);
        check_val("respawn_x", int'(bus.pos_x), 320);
        check_val("respawn_y", int'(bus.pos_y), 448);
        check_val("respawn_hop", int'(bus.hopping), 0);
        bus.state = PLAYING;
        idle(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
